// File: rtl/ahb_byte_master_pkg.sv
// Shared types and constants for the byte-stream driven AHB-Lite initiator.
package ahb_byte_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_ADDR,
    ST_BUS_DATA,
    ST_SEND_STATUS,
    ST_SEND_DATA,
    ST_SEND_NAK
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_NAK = 8'h3F;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

endpackage

// File: rtl/ahb_byte_master.sv
// Byte-stream command decoder that issues single-word AHB-Lite transfers
// and answers with a status byte plus, for reads, four data bytes.
module ahb_byte_master #(
  parameter int RX_TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        busy
);

  import ahb_byte_master_pkg::*;

  localparam int CNT_W = (RX_TIMEOUT > 2) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RX_TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic              is_write;
  logic              err_flag;
  logic [1:0]        byte_cnt;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic [CNT_W-1:0]  idle_cnt;

  logic rx_fire;
  logic last_byte;
  logic in_rx_body;
  logic timeout_hit;

  assign rx_ready    = (state == ST_IDLE) || (state == ST_GET_ADDR) || (state == ST_GET_DATA);
  assign rx_fire     = rx_valid && rx_ready;
  assign last_byte   = (byte_cnt == 2'd3);
  assign in_rx_body  = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
  assign timeout_hit = in_rx_body && !rx_fire && (idle_cnt == TIMEOUT_LAST);

  assign hsize  = HSIZE_WORD;
  assign hburst = HBURST_SINGLE;
  assign hprot  = HPROT_DATA;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode for command parsing, bus phases and response bytes.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (rx_fire) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) state_next = ST_GET_ADDR;
          else                                           state_next = ST_SEND_NAK;
        end
      end
      ST_GET_ADDR: begin
        if (timeout_hit)                state_next = ST_IDLE;
        else if (rx_fire && last_byte)  state_next = is_write ? ST_GET_DATA : ST_BUS_ADDR;
      end
      ST_GET_DATA: begin
        if (timeout_hit)                state_next = ST_IDLE;
        else if (rx_fire && last_byte)  state_next = ST_BUS_ADDR;
      end
      ST_BUS_ADDR: begin
        if (hready) state_next = ST_BUS_DATA;
      end
      ST_BUS_DATA: begin
        if (hready) state_next = ST_SEND_STATUS;
      end
      ST_SEND_STATUS: begin
        if (tx_ready) state_next = (!is_write && !err_flag) ? ST_SEND_DATA : ST_IDLE;
      end
      ST_SEND_DATA: begin
        if (tx_ready && last_byte) state_next = ST_IDLE;
      end
      ST_SEND_NAK: begin
        if (tx_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus and response outputs decoded from state so reset clears them at once.
  always_comb begin
    htrans   = (state == ST_BUS_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    hwrite   = (state == ST_BUS_ADDR) && is_write;
    haddr    = {addr_reg[31:2], 2'b00};
    hwdata   = wdata_reg;
    busy     = (state != ST_IDLE);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      ST_SEND_STATUS: begin
        tx_valid = 1'b1;
        tx_data  = err_flag ? RSP_ERR : RSP_OK;
      end
      ST_SEND_DATA: begin
        tx_valid = 1'b1;
        tx_data  = rdata_reg[7:0];
      end
      ST_SEND_NAK: begin
        tx_valid = 1'b1;
        tx_data  = RSP_NAK;
      end
      default: ;
    endcase
  end

  // Datapath: opcode latch, LSB-first shift registers and the byte counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_write  <= 1'b0;
      err_flag  <= 1'b0;
      byte_cnt  <= 2'd0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      rdata_reg <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_fire && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
            is_write <= (rx_data == OP_WRITE);
            byte_cnt <= 2'd0;
          end
        end
        ST_GET_ADDR: begin
          if (rx_fire) begin
            addr_reg <= {rx_data, addr_reg[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
          end else if (timeout_hit) begin
            byte_cnt <= 2'd0;
          end
        end
        ST_GET_DATA: begin
          if (rx_fire) begin
            wdata_reg <= {rx_data, wdata_reg[31:8]};
            byte_cnt  <= byte_cnt + 2'd1;
          end else if (timeout_hit) begin
            byte_cnt <= 2'd0;
          end
        end
        ST_BUS_DATA: begin
          if (hready) begin
            rdata_reg <= hrdata;
            err_flag  <= hresp;
          end
        end
        ST_SEND_STATUS: begin
          if (tx_ready) byte_cnt <= 2'd0;
        end
        ST_SEND_DATA: begin
          if (tx_ready) begin
            rdata_reg <= {8'h00, rdata_reg[31:8]};
            byte_cnt  <= byte_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Inter-byte idle counter; only runs while a command is partially received.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (in_rx_body && !timeout_hit) begin
      if (rx_fire) idle_cnt <= '0;
      else         idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ahb_byte_master.sv
// Directed testbench for ahb_byte_master with a short inter-byte timeout.
module tb_ahb_byte_master;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        busy;

  int tests_run;
  int tests_failed;
  int nonseq_cycles;
  int tx_valid_cycles;

  ahb_byte_master #(.RX_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with NONSEQ on the bus and with a response byte offered.
  always @(negedge clk) begin
    if (htrans == 2'b10) nonseq_cycles++;
    if (tx_valid) tx_valid_cycles++;
  end

  // Present one byte and hold it until the block takes it; ends on a negedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL send_byte_timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Wait for a response byte, accept it for one edge and return its value.
  task automatic get_byte(output logic [7:0] b);
    int n;
    n = 0;
    b = 8'hxx;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL get_byte_timeout: tx_valid=%b required 1", tx_valid);
    end
    b = tx_data;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tests_run++; if (htrans !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_htrans: got %b want 00", htrans); end
    tests_run++; if (haddr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_haddr: got %h want 0", haddr); end
    tests_run++; if (hwrite !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hwrite: got %b want 0", hwrite); end
    tests_run++; if (hwdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_hwdata: got %h want 0", hwdata); end
    tests_run++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_tx: got valid=%b data=%h want 0/00", tx_valid, tx_data); end
    tests_run++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_busy_ready: got busy=%b rx_ready=%b want 0/1", busy, rx_ready); end
    tests_run++; if (hsize !== 3'b010 || hburst !== 3'b000 || hprot !== 4'b0011) begin tests_failed++; $display("[TB] FAIL reset_constants: got %b %b %b want 010 000 0011", hsize, hburst, hprot); end
  endtask

  task automatic test_write();
    logic [7:0] cmd [9];
    logic [7:0] b;
    int ns0;
    cmd = '{8'h57, 8'h10, 8'h00, 8'h01, 8'hFF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ns0 = nonseq_cycles;
    hready = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(cmd[i]);
    tests_run++; if (htrans !== 2'b10 || hwrite !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_addr_phase: got htrans=%b hwrite=%b want 10/1", htrans, hwrite); end
    tests_run++; if (haddr !== 32'hFF01_0010) begin tests_failed++; $display("[TB] FAIL write_haddr: got %h want ff010010", haddr); end
    tests_run++; if (rx_ready !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_busy: got rx_ready=%b busy=%b want 0/1", rx_ready, busy); end
    @(negedge clk);
    tests_run++; if (htrans !== 2'b00 || hwdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL write_data_phase: got htrans=%b hwdata=%h want 00/deadbeef", htrans, hwdata); end
    get_byte(b);
    tests_run++; if (b !== 8'h4B) begin tests_failed++; $display("[TB] FAIL write_status: got %h want 4b", b); end
    tests_run++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL write_done: got tx_valid=%b busy=%b want 0/0", tx_valid, busy); end
    tests_run++; if (nonseq_cycles - ns0 !== 1) begin tests_failed++; $display("[TB] FAIL write_nonseq_count: got %0d want 1", nonseq_cycles - ns0); end
  endtask

  task automatic test_read_wait();
    logic [7:0] cmd [5];
    logic [7:0] exp [5];
    logic [7:0] b;
    cmd = '{8'h52, 8'h00, 8'h00, 8'hFF, 8'hFF};
    exp = '{8'h4B, 8'h78, 8'h56, 8'h34, 8'h12};
    hready = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(cmd[i]);
    tests_run++; if (htrans !== 2'b10 || hwrite !== 1'b0 || haddr !== 32'hFFFF_0000) begin tests_failed++; $display("[TB] FAIL read_addr_phase: got htrans=%b hwrite=%b haddr=%h want 10/0/ffff0000", htrans, hwrite, haddr); end
    @(negedge clk);
    hready = 1'b0;
    hrdata = 32'hAAAA_5555;
    repeat (3) @(negedge clk);
    tests_run++; if (htrans !== 2'b00 || tx_valid !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL read_wait_state: got htrans=%b tx_valid=%b busy=%b want 00/0/1", htrans, tx_valid, busy); end
    hready = 1'b1;
    hrdata = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      get_byte(b);
      tests_run++; if (b !== exp[i]) begin tests_failed++; $display("[TB] FAIL read_byte%0d: got %h want %h", i, b, exp[i]); end
    end
    tests_run++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL read_done: got tx_valid=%b busy=%b want 0/0", tx_valid, busy); end
  endtask

  task automatic test_error_backpressure();
    logic [7:0] cmd [5];
    logic [7:0] b;
    int tv0;
    cmd = '{8'h52, 8'h00, 8'h00, 8'h01, 8'hFF};
    hready = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(cmd[i]);
    @(negedge clk);
    hready = 1'b0;
    hresp  = 1'b1;
    @(negedge clk);
    hready = 1'b1;
    @(negedge clk);
    hresp  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h45) begin tests_failed++; $display("[TB] FAIL err_hold%0d: got valid=%b data=%h want 1/45", i, tx_valid, tx_data); end
      @(negedge clk);
    end
    get_byte(b);
    tests_run++; if (b !== 8'h45) begin tests_failed++; $display("[TB] FAIL err_status: got %h want 45", b); end
    tv0 = tx_valid_cycles;
    repeat (4) @(negedge clk);
    tests_run++; if (tx_valid_cycles - tv0 !== 0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_no_data: got extra_tx=%0d busy=%b want 0/0", tx_valid_cycles - tv0, busy); end
  endtask

  task automatic test_bad_opcode_align();
    logic [7:0] cmd [9];
    logic [7:0] b;
    cmd = '{8'h57, 8'h13, 8'h00, 8'h01, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
    send_byte(8'h00);
    get_byte(b);
    tests_run++; if (b !== 8'h3F) begin tests_failed++; $display("[TB] FAIL nak_byte: got %h want 3f", b); end
    tests_run++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL nak_idle: got busy=%b rx_ready=%b want 0/1", busy, rx_ready); end
    hready = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(cmd[i]);
    tests_run++; if (haddr !== 32'hFF01_0010 || hwdata !== 32'h0403_0201 || htrans !== 2'b10) begin tests_failed++; $display("[TB] FAIL align_haddr: got haddr=%h hwdata=%h htrans=%b want ff010010/04030201/10", haddr, hwdata, htrans); end
    get_byte(b);
    tests_run++; if (b !== 8'h4B) begin tests_failed++; $display("[TB] FAIL align_status: got %h want 4b", b); end
  endtask

  task automatic test_timeout();
    logic [7:0] cmd [5];
    logic [7:0] exp [5];
    logic [7:0] b;
    int ns0;
    int tv0;
    cmd = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
    exp = '{8'h4B, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    ns0 = nonseq_cycles;
    tv0 = tx_valid_cycles;
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (7) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_early: got busy=%b want 1 after 7 idle cycles", busy); end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_expire: got busy=%b rx_ready=%b want 0/1", busy, rx_ready); end
    repeat (2) @(negedge clk);
    tests_run++; if (nonseq_cycles - ns0 !== 0 || tx_valid_cycles - tv0 !== 0) begin tests_failed++; $display("[TB] FAIL timeout_silent: got nonseq=%0d tx=%0d want 0/0", nonseq_cycles - ns0, tx_valid_cycles - tv0); end
    hready = 1'b1;
    hrdata = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) send_byte(cmd[i]);
    tests_run++; if (haddr !== 32'h0000_0004 || htrans !== 2'b10) begin tests_failed++; $display("[TB] FAIL timeout_next_addr: got haddr=%h htrans=%b want 00000004/10", haddr, htrans); end
    for (int i = 0; i < 5; i++) begin
      get_byte(b);
      tests_run++; if (b !== exp[i]) begin tests_failed++; $display("[TB] FAIL timeout_next_byte%0d: got %h want %h", i, b, exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] cmd [5];
    cmd = '{8'h52, 8'h00, 8'h00, 8'h01, 8'hFF};
    hready = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(cmd[i]);
    @(negedge clk);
    hready = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_waiting: got busy=%b want 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++; if (htrans !== 2'b00 || tx_valid !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_state: got htrans=%b tx_valid=%b busy=%b rx_ready=%b want 00/0/0/1", htrans, tx_valid, busy, rx_ready); end
    rst_n  = 1'b1;
    hready = 1'b1;
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    nonseq_cycles   = 0;
    tx_valid_cycles = 0;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    hrdata   = 32'h0;
    hready   = 1'b1;
    hresp    = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_error_backpressure();
    test_bad_opcode_align();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ahb_byte_master.md
Name: ahb_byte_master

Overview:
- AHB-Lite initiator driven by a byte stream. It turns host commands (e.g. from a UART RX/TX pair or a debug FIFO) into single-word AHB-Lite transfers, and returns status and read data as bytes.
- Sits on the SoC data-side fabric as a second master-side port, addressing the same slaves as the core: UART at 0xFF01_xxxx, ROM at 0xFFFF_xxxx.
- Used for board bring-up, memory peek/poke and bootloading without JTAG.

Parameters:
- RX_TIMEOUT, 50000: idle cycles allowed between bytes of one command before the partial command is discarded; minimum 2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- rx_data  in  8  command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts tx_data
- haddr  out  32  AHB address
- htrans  out  2  AHB transfer type (IDLE/NONSEQ only)
- hwrite  out  1  AHB write
- hsize  out  3  constant 3'b010
- hburst  out  3  constant 3'b000
- hprot  out  4  constant 4'b0011
- hwdata  out  32  AHB write data
- hrdata  in  32  AHB read data
- hready  in  1  AHB bus ready
- hresp  in  1  AHB error response
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous and active-low.
- Reset values: state IDLE, htrans=2'b00, haddr=0, hwrite=0, hwdata=0, tx_valid=0, tx_data=0, busy=0, timeout counter=0. rx_ready is decoded from state, so it reads 1 after reset.
- Command format: opcode byte, then 4 address bytes LSB first, then (write only) 4 data bytes LSB first.
  - 0x57 'W' = write word; 0x52 'R' = read word.
  - haddr[1:0] is forced to 2'b00.
- A byte transfers on the clk edge where rx_valid && rx_ready. rx_ready=1 only in IDLE, GET_ADDR and GET_DATA.
- States:
  - IDLE: on accepting 'W' or 'R', latch the opcode and go to GET_ADDR with the byte count cleared. Any other byte goes to SEND_NAK.
  - GET_ADDR: shift bytes into the address register. After the 4th byte: 'W' goes to GET_DATA, 'R' goes to BUS_ADDR.
  - GET_DATA: shift 4 bytes into the write register, then go to BUS_ADDR.
  - BUS_ADDR: drive htrans=NONSEQ, haddr, hwrite. Stay until hready=1 is sampled (address phase accepted). Then htrans=IDLE and go to BUS_DATA.
  - BUS_DATA: hwdata is held stable from BUS_ADDR entry until completion. On the edge with hready=1:
    - capture hrdata into the read register;
    - capture hresp into the error flag;
    - go to SEND_STATUS.
    - hready=0 wait states are unbounded, with no timeout.
  - SEND_STATUS: tx_valid=1, tx_data=0x4B 'K' (OK) or 0x45 'E' (error). When tx_ready: a read without error goes to SEND_DATA with the byte count cleared; otherwise go to IDLE.
  - SEND_DATA: send the 4 read bytes LSB first, each held until tx_ready, then go to IDLE.
  - SEND_NAK: send 0x3F '?' once, then go to IDLE.
- Handshake rules:
  - tx_data must not change while tx_valid=1 && !tx_ready.
  - tx_valid drops in the cycle after the last accepted byte.
- Exactly one NONSEQ cycle is presented per command, and never in two consecutive transfers without an IDLE between them.
- Timeout: in GET_ADDR or GET_DATA, the counter increments each cycle without an accepted byte and clears on each accepted byte. When it reaches RX_TIMEOUT-1, the block returns to IDLE silently (no response). The counter clears in every other state.
- Reset mid-operation: the return to reset values applies on that edge, including htrans=IDLE. The slave side is reset by the same rst_n domain.
- A byte that arrives while rx_ready=0 stays pending on the source; it is not dropped by this block.

Decomposition:
- ahb_byte_master_pkg holds:
  - the state enum;
  - opcode constants OP_WRITE=8'h57 and OP_READ=8'h52;
  - response constants RSP_OK=8'h4B, RSP_ERR=8'h45 and RSP_NAK=8'h3F;
  - HTRANS_IDLE and HTRANS_NONSEQ;
  - HSIZE_WORD, HBURST_SINGLE and HPROT_DATA.
- No sub-module: a single FSM with shift registers and one counter.

Test Plan:
- Write, no wait states: send 57, 10,00,01,FF, EF,BE,AD,DE → one NONSEQ with haddr=FF01_0010 and hwrite=1, hwdata=DEADBEEF in the next cycle, response 4B.
- Read with 3 wait states: send 52, 00,00,FF,FF; slave returns 12345678 → response 4B,78,56,34,12.
- Error plus tx backpressure: read with two-cycle hresp=1 error; tx_ready held low for 5 cycles → 45 stays stable until accepted, no data bytes follow, block returns to IDLE.
- Bad opcode and alignment: byte 0x00 → response 3F. Write to address 0x...13 → haddr ends in 0x10.
- Inter-byte timeout: with RX_TIMEOUT=8, send 57,01 then stall 8 cycles → no AHB transfer and no tx byte; a following full read command works normally.
- Reset mid-operation: assert rst_n=0 during BUS_DATA wait → next edge gives htrans=00, tx_valid=0, busy=0, rx_ready=1.
